// File: rtl/rv32i_types.sv
// Shared RV32 types for the M-extension unit: op encoding, FSM states,
// iteration count and operand-signedness helpers.
package rv32i_types;

    localparam int MDU_ITERS = 32;

    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } m_funct3_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mdu_state_t;

    function automatic logic rs1_signed(input m_funct3_t f);
        return f inside {MUL, MULH, MULHSU, DIV, REM};
    endfunction

    function automatic logic rs2_signed(input m_funct3_t f);
        return f inside {MUL, MULH, DIV, REM};
    endfunction

    function automatic logic is_div(input m_funct3_t f);
        return f[2];
    endfunction

    function automatic logic is_rem(input m_funct3_t f);
        return f[2] & f[1];
    endfunction

endpackage

// File: rtl/m_extension_unit.sv
// Iterative RV32M multiply/divide unit: sign-magnitude shift-add multiply and
// restoring divide over MDU_ITERS cycles, holding the result until EX advances.
module m_extension_unit
    import rv32i_types::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            m_extension_load,
    input  m_funct3_t       funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    input  logic            ex_advance,
    output logic            m_extension_resp,
    output logic [XLEN-1:0] m_extension_out,
    output logic            busy
);

    localparam int CW = $clog2(MDU_ITERS);

    mdu_state_t        state;
    m_funct3_t         op;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic              neg;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   rem;
    logic [CW-1:0]     count;
    logic [XLEN-1:0]   result;
    logic              resp;

    logic              a_neg, b_neg, sign_in;
    logic [XLEN-1:0]   a_abs, b_abs;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   special_res;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift, div_trial;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

    // Operand conditioning for the op presented in IDLE.
    always_comb begin
        a_neg    = rs1_signed(funct3) & rs1_data[XLEN-1];
        b_neg    = rs2_signed(funct3) & rs2_data[XLEN-1];
        a_abs    = a_neg ? -rs1_data : rs1_data;
        b_abs    = b_neg ? -rs2_data : rs2_data;
        sign_in  = is_rem(funct3) ? a_neg : (a_neg ^ b_neg);
        div_zero = is_div(funct3) && (rs2_data == '0);
        div_ovf  = (funct3 == DIV || funct3 == REM) &&
                   (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
        special_res = '0;
        if (div_zero)
            special_res = is_rem(funct3) ? rs1_data : '1;
        else if (div_ovf)
            special_res = is_rem(funct3) ? '0 : rs1_data;
    end

    // One iteration step; acc low half holds the multiplier / dividend bits.
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_a} : {(XLEN+1){1'b0}});
        div_shift = {rem, acc[XLEN-1]};
        div_trial = div_shift - {1'b0, mag_b};
    end

    always_comb begin
        prod_fix = neg ? -acc : acc;
        quo_fix  = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem_fix  = neg ? -rem : rem;
        case (op)
            MUL:                 fix_res = prod_fix[XLEN-1:0];
            MULH, MULHSU, MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
            DIV, DIVU:           fix_res = quo_fix;
            default:             fix_res = rem_fix;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            op     <= MUL;
            mag_a  <= '0;
            mag_b  <= '0;
            neg    <= 1'b0;
            acc    <= '0;
            rem    <= '0;
            count  <= '0;
            result <= '0;
            resp   <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
            resp  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (m_extension_load) begin
                        op <= funct3;
                        if (div_zero || div_ovf) begin
                            result <= special_res;
                            resp   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            mag_a <= a_abs;
                            mag_b <= b_abs;
                            neg   <= sign_in;
                            acc   <= {{XLEN{1'b0}}, is_div(funct3) ? a_abs : b_abs};
                            rem   <= '0;
                            count <= '0;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (!m_extension_load) begin
                        state <= IDLE;
                    end else begin
                        if (is_div(op)) begin
                            // Restore by keeping the shifted value when the trial goes negative.
                            rem <= div_trial[XLEN] ? div_shift[XLEN-1:0] : div_trial[XLEN-1:0];
                            acc <= {acc[2*XLEN-1:XLEN], acc[XLEN-2:0], ~div_trial[XLEN]};
                        end else begin
                            acc <= {mul_sum, acc[XLEN-1:1]};
                        end
                        count <= count + 1'b1;
                        if (count == CW'(MDU_ITERS - 1))
                            state <= FIX;
                    end
                end
                FIX: begin
                    if (!m_extension_load) begin
                        state <= IDLE;
                    end else begin
                        result <= fix_res;
                        resp   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (ex_advance) begin
                        resp  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign m_extension_resp = resp;
    assign m_extension_out  = result;
    assign busy             = (state != IDLE);

endmodule

// File: tb/tb_m_extension_unit.sv
// Directed and randomized checks of m_extension_unit against a 64-bit
// arithmetic reference model, including latency, hold, flush and reset.
module tb_m_extension_unit;
    import rv32i_types::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic        flush = 1'b0;
    logic        ex_advance = 1'b0;
    m_funct3_t   funct3 = MUL;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        resp;
    logic [31:0] out;
    logic        busy;

    int          total = 0;
    int          bad = 0;
    logic [31:0] last_out = '0;

    m_extension_unit #(.XLEN(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .m_extension_load (load),
        .funct3           (funct3),
        .rs1_data         (rs1),
        .rs2_data         (rs2),
        .flush            (flush),
        .ex_advance       (ex_advance),
        .m_extension_resp (resp),
        .m_extension_out  (out),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    function automatic logic is_special(input m_funct3_t f, input logic [31:0] a, input logic [31:0] b);
        return (f inside {DIV, DIVU, REM, REMU} && b == 32'd0) ||
               (f inside {DIV, REM} && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] ref_model(input m_funct3_t f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        p  = '0;
        case (f)
            MUL:    begin p = sa * sb; return p[31:0];  end
            MULH:   begin p = sa * sb; return p[63:32]; end
            MULHSU: begin p = sa * ub; return p[63:32]; end
            MULHU:  begin p = ua * ub; return p[63:32]; end
            DIV:    begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
            DIVU:   begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
            REM:    begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            default: begin if (b == 0) return a; return a % b; end
        endcase
    endfunction

    // Issues one op at the next cycle 0 and checks latency, result, hold and release.
    task automatic run_op(input m_funct3_t f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int stall, input bit tie_adv);
        int lat;
        lat = is_special(f, a, b) ? 1 : 34;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        load = 1'b1; funct3 = f; rs1 = a; rs2 = b; ex_advance = tie_adv;
        for (int c = 1; c < lat; c++) begin
            @(negedge clk);
            chk("early_resp", resp, 0);
            if (c == 1) begin
                chk("busy_calc", busy, 1);
                chk("out_hold", out, last_out);
            end
        end
        for (int k = 0; k <= stall; k++) begin
            @(negedge clk);
            chk("resp", resp, 1);
            chk("result", out, exp);
            ex_advance = tie_adv | (k == stall);
        end
        @(negedge clk);
        chk("resp_drop", resp, 0);
        chk("busy_drop", busy, 0);
        load = 1'b0; ex_advance = 1'b0;
        last_out = exp;
    endtask

    initial begin
        logic [31:0] a, b;
        m_funct3_t   f;

        repeat (3) @(negedge clk);
        chk("rst_resp", resp, 0);
        chk("rst_out", out, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;

        run_op(MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, 1'b1);
        run_op(MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, 1'b0);
        run_op(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 1'b0);
        run_op(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
        run_op(DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 0, 1'b0);
        run_op(REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 0, 1'b0);
        run_op(DIVU,   32'd100,       32'd7,         32'd14,        0, 1'b0);
        run_op(REMU,   32'd100,       32'd7,         32'd2,         0, 1'b0);
        run_op(DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 0, 1'b0);
        run_op(REM,    32'd5,         32'd0,         32'd5,         0, 1'b0);
        run_op(DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1'b0);
        run_op(REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         0, 1'b0);
        run_op(DIVU,   32'd100,       32'd7,         32'd14,        3, 1'b0);

        // Flush at cycle 10 of a DIV, then MULHU issued at cycle 12.
        @(negedge clk);
        load = 1'b1; funct3 = DIV; rs1 = 32'd1000; rs2 = 32'd3;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            chk("flush_noresp", resp, 0);
        end
        flush = 1'b1;
        @(negedge clk);
        chk("flush_idle", busy, 0);
        chk("flush_resp", resp, 0);
        chk("flush_out", out, last_out);
        flush = 1'b0; load = 1'b0;
        run_op(MULHU, 32'h1234_5678, 32'h9ABC_DEF0, ref_model(MULHU, 32'h1234_5678, 32'h9ABC_DEF0), 0, 1'b0);

        // Load dropped mid-calculation aborts without a response.
        @(negedge clk);
        load = 1'b1; funct3 = DIVU; rs1 = 32'd77; rs2 = 32'd5;
        repeat (5) @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        chk("abort_idle", busy, 0);
        repeat (35) begin
            @(negedge clk);
            chk("abort_noresp", resp, 0);
        end

        // Asynchronous reset at cycle 20 of a MUL.
        @(negedge clk);
        load = 1'b1; funct3 = MUL; rs1 = 32'd3; rs2 = 32'd4;
        repeat (20) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_resp", resp, 0);
        chk("arst_out", out, 0);
        chk("arst_busy", busy, 0);
        load = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        last_out = '0;
        repeat (40) begin
            @(negedge clk);
            chk("post_rst_noresp", resp, 0);
        end

        for (int i = 0; i < 40; i++) begin
            f = m_funct3_t'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0:       a = 32'h8000_0000;
                1:       a = 32'hFFFF_FFFF;
                2:       a = 32'd0;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       b = 32'hFFFF_FFFF;
                1:       b = 32'd0;
                2:       b = $urandom_range(1, 15);
                default: b = $urandom;
            endcase
            run_op(f, a, b, ref_model(f, a, b), int'($urandom_range(0, 2)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
